// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray-code helpers used by the write control,
// read control and pointer synchronizers.
package fifo_pkg;

    localparam int FIFO_ADD_WIDTH = 4;
    localparam int FIFO_PTR_WIDTH = FIFO_ADD_WIDTH + 1;

    // Helpers work on a wide word so any pointer width can share them;
    // callers zero-extend on the way in and truncate on the way out.
    typedef logic [31:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle between the FIFO write control and its partners
// (producer, memory, read-domain synchronizer).
interface fifo_wr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADD_WIDTH = FIFO_ADD_WIDTH
);

    logic                 wr_inc;
    logic [ADD_WIDTH:0]   wq2_rd_ptr;
    logic                 wr_ovf_clr;
    logic [ADD_WIDTH-1:0] wr_addr;
    logic [ADD_WIDTH:0]   wr_ptr;
    logic                 wr_full;
    logic                 wr_afull;
    logic [ADD_WIDTH:0]   wr_level;
    logic                 wr_ovf;

    modport master (
        input  wr_inc, wq2_rd_ptr, wr_ovf_clr,
        output wr_addr, wr_ptr, wr_full, wr_afull, wr_level, wr_ovf
    );

    modport slave (
        output wr_inc, wq2_rd_ptr, wr_ovf_clr,
        input  wr_addr, wr_ptr, wr_full, wr_afull, wr_level, wr_ovf
    );

endinterface

// File: rtl/fifo_gray_cnt.sv
// Binary/Gray pointer register pair with increment enable; shared by the
// write and read side controls of the asynchronous FIFO.
module fifo_gray_cnt
    import fifo_pkg::*;
#(
    parameter int W = FIFO_PTR_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-2:0] addr,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray,
    output logic [W-1:0] gray_next
);

    logic [W-1:0] bin;

    assign bin_next  = bin + W'(inc);
    assign gray_next = W'(bin2gray(32'(bin_next)));
    assign addr      = bin[W-2:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side control of the asynchronous FIFO: pointers, full, level and
// sticky overflow. Define FIFO_WR_AFULL_EN to build the almost-full flag.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADD_WIDTH    = FIFO_ADD_WIDTH,
    parameter int AFULL_THRESH = 12
) (
    input logic          wr_clk,
    input logic          wr_rst,
    fifo_wr_ctrl_if.master bus
);

    localparam int PW = ADD_WIDTH + 1;

    logic          wr_acc;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] gray;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          full;
    logic [PW-1:0] level;
    logic          ovf;
    logic          afull;

    assign wr_acc = bus.wr_inc & ~full;

    fifo_gray_cnt #(.W(PW)) u_ptr (
        .clk       (wr_clk),
        .rst       (wr_rst),
        .inc       (wr_acc),
        .addr      (bus.wr_addr),
        .bin_next  (wbin_next),
        .gray      (gray),
        .gray_next (gray_next)
    );

    // Full when the next write pointer has lapped the read pointer exactly
    // once: top two Gray bits inverted, the rest equal.
    assign full_next  = (gray_next == {~bus.wq2_rd_ptr[ADD_WIDTH:ADD_WIDTH-1],
                                       bus.wq2_rd_ptr[ADD_WIDTH-2:0]});
    assign rbin       = PW'(gray2bin(32'(bus.wq2_rd_ptr)));
    assign level_next = wbin_next - rbin;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            full  <= 1'b0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            full  <= full_next;
            level <= level_next;
            ovf   <= (bus.wr_inc & full) | (ovf & ~bus.wr_ovf_clr);
        end
    end

`ifdef FIFO_WR_AFULL_EN
    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            afull <= 1'b0;
        end else begin
            afull <= (32'(level_next) >= AFULL_THRESH);
        end
    end
`else
    assign afull = 1'b0;
`endif

    assign bus.wr_ptr   = gray;
    assign bus.wr_full  = full;
    assign bus.wr_level = level;
    assign bus.wr_ovf   = ovf;
    assign bus.wr_afull = afull;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed plus randomized bench for fifo_wr_ctrl against an occupancy-count
// reference model (write/read item totals).
module tb_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;
    localparam int TH    = 12;
`ifdef FIFO_WR_AFULL_EN
    localparam bit AFEN = 1'b1;
`else
    localparam bit AFEN = 1'b0;
`endif

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b0;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_ctrl_if #(.ADD_WIDTH(AW)) bus ();

    fifo_wr_ctrl #(.ADD_WIDTH(AW), .AFULL_THRESH(TH)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    int total  = 0;
    int passed = 0;

    // Model: totals of items written and read, occupancy is their difference.
    int m_w;
    int rd;
    int m_level;
    bit m_full;
    bit m_ovf;
    bit m_afull;
    logic [PW-1:0] prev_ptr;

    function automatic logic [PW-1:0] gray_of(input int n);
        int v;
        v = n % 32;
        return PW'(v ^ (v >> 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input bit rst_n, input bit inc, input bit clr);
        bit acc;
        acc = 1'b0;
        wr_rst          = rst_n;
        bus.wr_inc      = inc;
        bus.wr_ovf_clr  = clr;
        bus.wq2_rd_ptr  = gray_of(rd);
        if (!rst_n) begin
            m_w = 0; m_level = 0; m_full = 0; m_ovf = 0; m_afull = 0;
        end else begin
            acc     = inc && !m_full;
            m_ovf   = (inc && m_full) || (m_ovf && !clr);
            m_w     = m_w + int'(acc);
            m_level = m_w - rd;
            m_full  = (m_level == DEPTH);
            m_afull = AFEN && (m_level >= TH);
        end
        @(posedge wr_clk);
        @(negedge wr_clk);
        check("addr",  32'(bus.wr_addr),  32'(m_w % DEPTH));
        check("ptr",   32'(bus.wr_ptr),   32'(gray_of(m_w)));
        check("full",  32'(bus.wr_full),  32'(m_full));
        check("level", 32'(bus.wr_level), 32'(m_level));
        check("ovf",   32'(bus.wr_ovf),   32'(m_ovf));
        check("afull", 32'(bus.wr_afull), 32'(m_afull));
        if (rst_n) check("gray_step", 32'($countones(prev_ptr ^ bus.wr_ptr)), 32'(acc));
        prev_ptr = bus.wr_ptr;
    endtask

    initial begin
        bus.wr_inc     = 1'b0;
        bus.wr_ovf_clr = 1'b0;
        bus.wq2_rd_ptr = '0;
        rd       = 0;
        prev_ptr = '0;
        m_w = 0; m_level = 0; m_full = 0; m_ovf = 0; m_afull = 0;
        @(negedge wr_clk);

        // Reset held with write requests
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rst_level", 32'(bus.wr_level), 32'd0);
        check("rst_addr",  32'(bus.wr_addr),  32'd0);

        // Fill
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i == 11) check("afull_at_11", 32'(bus.wr_afull), 32'd0);
            if (i == 12) check("afull_at_12", 32'(bus.wr_afull), 32'(AFEN));
        end
        check("fill_ptr",   32'(bus.wr_ptr),   32'b11000);
        check("fill_full",  32'(bus.wr_full),  32'd1);
        check("fill_level", 32'(bus.wr_level), 32'd16);

        // Overflow and its clear
        repeat (3) step(1'b1, 1'b1, 1'b0);
        check("ovf_set",       32'(bus.wr_ovf),   32'd1);
        check("ovf_level",     32'(bus.wr_level), 32'd16);
        check("ovf_addr",      32'(bus.wr_addr),  32'd0);
        step(1'b1, 1'b1, 1'b1);
        check("ovf_set_wins",  32'(bus.wr_ovf),   32'd1);
        step(1'b1, 1'b0, 1'b1);
        check("ovf_cleared",   32'(bus.wr_ovf),   32'd0);

        // Drain five via the synchronized read pointer, then refill
        rd = 5;
        step(1'b1, 1'b0, 1'b0);
        check("drain_full",  32'(bus.wr_full),  32'd0);
        check("drain_level", 32'(bus.wr_level), 32'd11);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        check("refill_full", 32'(bus.wr_full), 32'd1);
        check("refill_ptr",  32'(bus.wr_ptr),  32'b11111);

        // Wrap the binary pointer past 31
        rd = 16;
        step(1'b1, 1'b0, 1'b0);
        repeat (11) step(1'b1, 1'b1, 1'b0);
        check("wrap_full",  32'(bus.wr_full),  32'd1);
        check("wrap_ptr",   32'(bus.wr_ptr),   32'd0);
        check("wrap_level", 32'(bus.wr_level), 32'd16);

        // Randomized traffic with occasional mid-stream reset
        repeat (600) begin
            if ($urandom_range(0, 149) == 0) begin
                rd = 0;
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                if (rd < m_w && $urandom_range(0, 2) == 0) rd = rd + 1;
                step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
